// File: rtl/round_robin_fifo_distributor.sv
// rtl/round_robin_fifo_distributor.sv - splits one input stream round-robin into four channel FIFOs
// Optional DIST_SKIP_FULL_EN: when defined, full channels are skipped instead of dropping the word.
module round_robin_fifo_distributor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [3:0]       ren,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       valid,
  output logic [3:0]       full,
  output logic             drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [PW-1:0]    wptr [4];
  logic [PW-1:0]    rptr [4];
  logic [CW-1:0]    count [4];
  logic [WIDTH-1:0] dout [4];
  logic [1:0]       rr;
  logic [1:0]       rr_next;
  logic [1:0]       tgt;
  logic             wr;
  logic [3:0]       wr_ch;
  logic [3:0]       pop;

  always_comb begin
    full = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      full[i] = (count[i] == CW'(DEPTH));
      pop[i]  = ren[i] && (count[i] != '0);
    end
  end

`ifdef DIST_SKIP_FULL_EN
  // Scan from the farthest offset down so the nearest non-full channel to rr wins.
  always_comb begin
    tgt     = rr;
    wr      = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (!full[rr + 2'(j)]) begin
        tgt = rr + 2'(j);
        wr  = din_valid;
      end
    end
    rr_next = wr ? tgt + 2'd1 : rr;
  end
`else
  // rr advances on every offered word, accepted or dropped.
  always_comb begin
    tgt     = rr;
    wr      = din_valid && !full[rr];
    rr_next = din_valid ? rr + 2'd1 : rr;
  end
`endif

  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < 4; i++) begin
      wr_ch[i] = wr && (tgt == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem[tgt][wptr[tgt]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr    <= '0;
      drop  <= 1'b0;
      valid <= '0;
      for (int i = 0; i < 4; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
        dout[i]  <= '0;
      end
    end else begin
      rr   <= rr_next;
      drop <= din_valid && !wr;
      for (int i = 0; i < 4; i++) begin
        if (wr_ch[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])   rptr[i] <= rptr[i] + 1'b1;
        count[i] <= count[i] + CW'(wr_ch[i]) - CW'(pop[i]);
        dout[i]  <= pop[i] ? mem[i][rptr[i]] : '0;
        valid[i] <= pop[i];
      end
    end
  end

  assign a = dout[0];
  assign b = dout[1];
  assign c = dout[2];
  assign d = dout[3];

endmodule
